// File: rtl/nes_pad_responder.sv
// NES controller pad emulator: synchronizes the console latch/clock strobes and
// shifts out the active-low button state one bit per console clock rising edge.
module nes_pad_responder #(
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [7:0]  buttons,
  input  logic        latch_in,
  input  logic        ctrl_clk_in,
  output logic        data,
  output logic [3:0]  bit_idx,
  output logic        frame_done,
  output logic        overrun,
  output logic [15:0] poll_count
);

  localparam int unsigned FRAME_BITS = 8;
  localparam int unsigned IDX_W      = 4;
  localparam int unsigned CNT_W      = 16;

  if (SYNC_STAGES < 2 || SYNC_STAGES > 4) begin : g_bad_sync_stages
    $error("nes_pad_responder: SYNC_STAGES must be in 2..4");
  end

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LOAD  = 2'd1,
    SHIFT = 2'd2,
    DONE  = 2'd3
  } state_e;

  state_e                   state_q, state_d;
  logic [SYNC_STAGES-1:0]   latch_sync_q, latch_sync_d;
  logic [SYNC_STAGES-1:0]   cclk_sync_q, cclk_sync_d;
  logic                     latch_dly_q, latch_dly_d;
  logic                     cclk_dly_q, cclk_dly_d;
  logic [FRAME_BITS-1:0]    sr_q, sr_d;
  logic [IDX_W-1:0]         bit_idx_q, bit_idx_d;
  logic                     frame_done_q, frame_done_d;
  logic                     overrun_q, overrun_d;
  logic [CNT_W-1:0]         poll_count_q, poll_count_d;

  logic latch_rise, latch_fall, cclk_rise;

  // Edge detection compares the last synchronizer stage with one extra delay flop.
  always_comb begin
    latch_sync_d = {latch_sync_q[SYNC_STAGES-2:0], latch_in};
    cclk_sync_d  = {cclk_sync_q[SYNC_STAGES-2:0], ctrl_clk_in};
    latch_dly_d  = latch_sync_q[SYNC_STAGES-1];
    cclk_dly_d   = cclk_sync_q[SYNC_STAGES-1];
    latch_rise   =  latch_sync_q[SYNC_STAGES-1] & ~latch_dly_q;
    latch_fall   = ~latch_sync_q[SYNC_STAGES-1] &  latch_dly_q;
    cclk_rise    =  cclk_sync_q[SYNC_STAGES-1]  & ~cclk_dly_q;
  end

  // Next-state logic; a latch rise outranks any same-cycle shift clock edge.
  always_comb begin
    state_d      = state_q;
    sr_d         = sr_q;
    bit_idx_d    = bit_idx_q;
    frame_done_d = 1'b0;
    overrun_d    = 1'b0;
    poll_count_d = poll_count_q;
    if (latch_rise && state_q != LOAD) begin
      state_d   = LOAD;
      sr_d      = ~buttons;
      bit_idx_d = '0;
    end else begin
      unique case (state_q)
        IDLE: ;
        LOAD: begin
          sr_d      = ~buttons;
          bit_idx_d = '0;
          if (latch_fall) begin
            state_d      = SHIFT;
            poll_count_d = poll_count_q + CNT_W'(1);
          end
        end
        SHIFT: begin
          if (cclk_rise) begin
            sr_d      = {1'b0, sr_q[FRAME_BITS-1:1]};
            bit_idx_d = bit_idx_q + IDX_W'(1);
            if (bit_idx_q == IDX_W'(FRAME_BITS - 1)) begin
              state_d      = DONE;
              frame_done_d = 1'b1;
            end
          end
        end
        DONE: begin
          if (cclk_rise) overrun_d = 1'b1;
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q      <= IDLE;
      latch_sync_q <= '0;
      cclk_sync_q  <= '0;
      latch_dly_q  <= 1'b0;
      cclk_dly_q   <= 1'b0;
      sr_q         <= '1;
      bit_idx_q    <= '0;
      frame_done_q <= 1'b0;
      overrun_q    <= 1'b0;
      poll_count_q <= '0;
    end else begin
      state_q      <= state_d;
      latch_sync_q <= latch_sync_d;
      cclk_sync_q  <= cclk_sync_d;
      latch_dly_q  <= latch_dly_d;
      cclk_dly_q   <= cclk_dly_d;
      sr_q         <= sr_d;
      bit_idx_q    <= bit_idx_d;
      frame_done_q <= frame_done_d;
      overrun_q    <= overrun_d;
      poll_count_q <= poll_count_d;
    end
  end

  assign data       = sr_q[0];
  assign bit_idx    = bit_idx_q;
  assign frame_done = frame_done_q;
  assign overrun    = overrun_q;
  assign poll_count = poll_count_q;

endmodule
